// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and raster helper functions,
// used by the timing controller and by the renderers.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_CW       = 10;

    // Total pixels per line or lines per frame; used for both axes.
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic logic in_sync_window(
        input int unsigned pos,
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync
    );
        return (pos >= active + fp) && (pos < active + fp + sync);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_trigger_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for an async input.
// Output pulse is one clk wide, three clk edges after the input rises.
module trigger_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Parametrised VGA raster generator: counters, syncs, active flag, line/frame
// strobes and a frame-latched light-gun trigger.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned PIX_DIV  = 1,
    parameter int unsigned CW       = VGA_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trigger,
    output logic [CW-1:0] col_count,
    output logic [CW-1:0] row_count,
    output logic          valid,
    output logic          hsync,
    output logic          vsync,
    output logic          line_tick,
    output logic          frame_tick,
    output logic          trigger_pulse,
    output logic          trigger_frame
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    row_q, row_d;
    logic             valid_q, valid_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_tick_q, line_tick_d;
    logic             frame_tick_q, frame_tick_d;
    logic             flag_q, flag_d;
    logic             trig_frame_q, trig_frame_d;

    logic pix_en;
    logic col_last;
    logic row_last;
    logic frame_wrap;
    logic trig_pulse;

    trigger_sync u_trigger_sync (
        .clk   (clk),
        .reset (reset),
        .din   (trigger),
        .pulse (trig_pulse)
    );

    always_comb begin
        pix_en     = (div_q == DIV_LAST);
        col_last   = (col_q == H_LAST);
        row_last   = (row_q == V_LAST);
        frame_wrap = pix_en & col_last & row_last;

        div_d = pix_en ? '0 : div_q + 1'b1;
        col_d = col_q;
        row_d = row_q;
        if (pix_en) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
        end

        // Decoded from the next counts so flags land on the same cycle as the counters.
        valid_d = (32'(col_d) < H_ACTIVE) && (32'(row_d) < V_ACTIVE);
        hsync_d = in_sync_window(32'(col_d), H_ACTIVE, H_FP, H_SYNC) ? HS_POL : ~HS_POL;
        vsync_d = in_sync_window(32'(row_d), V_ACTIVE, V_FP, V_SYNC) ? VS_POL : ~VS_POL;

        line_tick_d  = pix_en & col_last;
        frame_tick_d = frame_wrap;

        // A pulse visible in the frame_tick cycle is absorbed after the wrap,
        // so it belongs to the new frame; one seen just before the wrap still counts.
        flag_d       = frame_wrap ? 1'b0 : (flag_q | trig_pulse);
        trig_frame_d = frame_wrap ? (flag_q | trig_pulse) : trig_frame_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q        <= '0;
            col_q        <= H_LAST;
            row_q        <= V_LAST;
            valid_q      <= 1'b0;
            hsync_q      <= ~HS_POL;
            vsync_q      <= ~VS_POL;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            flag_q       <= 1'b0;
            trig_frame_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= valid_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
            flag_q       <= flag_d;
            trig_frame_q <= trig_frame_d;
        end
    end

    assign col_count     = col_q;
    assign row_count     = row_q;
    assign valid         = valid_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign line_tick     = line_tick_q;
    assign frame_tick    = frame_tick_q;
    assign trigger_pulse = trig_pulse;
    assign trigger_frame = trig_frame_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two instances (PIX_DIV 1 and 3) on a small raster,
// compared every clk against a frame/pixel-index reference model.
module tb_vga_timing_ctrl;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int NT  = HT * VT;
    localparam int CW  = 4;

    typedef struct {
        int col;
        int row;
        bit v;
        bit hs;
        bit vs;
        bit lt;
        bit ft;
        int f;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic trigger;

    logic [CW-1:0] col1, row1, col3, row3;
    logic v1, hs1, vs1, lt1, ft1, tp1, tf1;
    logic v3, hs3, vs3, lt3, ft3, tp3, tf3;

    int n_chk  = 0;
    int n_fail = 0;
    int k;
    bit hist[$];
    bit had1[int];
    bit had3[int];
    int last_ft1, last_ft3, last_lt1, last_lt3;
    int vcount, vframes;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .CW(CW)
    ) dut1 (
        .clk(clk), .reset(reset), .trigger(trigger),
        .col_count(col1), .row_count(row1), .valid(v1), .hsync(hs1), .vsync(vs1),
        .line_tick(lt1), .frame_tick(ft1), .trigger_pulse(tp1), .trigger_frame(tf1)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3), .CW(CW)
    ) dut3 (
        .clk(clk), .reset(reset), .trigger(trigger),
        .col_count(col3), .row_count(row3), .valid(v3), .hsync(hs3), .vsync(vs3),
        .line_tick(lt3), .frame_tick(ft3), .trigger_pulse(tp3), .trigger_frame(tf3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t (k=%0d): got %0d expected %0d", tag, $time, k, got, exp);
        end
    endtask

    // Position after kk clk edges since reset release: pixel p = kk/D, and the
    // p-th pixel (1-based) sits at raster index p-1 modulo the frame size.
    function automatic exp_t model(input int D, input int kk);
        exp_t e;
        int p, idx;
        p = kk / D;
        if (p == 0) begin
            e.col = HT - 1; e.row = VT - 1;
            e.v = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.lt = 1'b0; e.ft = 1'b0;
            e.f = -1;
        end else begin
            idx   = (p - 1) % NT;
            e.col = idx % HT;
            e.row = idx / HT;
            e.v   = (e.col < HA) && (e.row < VA);
            e.hs  = !((e.col >= HA + HFP) && (e.col < HA + HFP + HSW));
            e.vs  = !((e.row >= VA + VFP) && (e.row < VA + VFP + VSW));
            e.lt  = (kk % D == 0) && (e.col == 0);
            e.ft  = (kk % D == 0) && (idx == 0);
            e.f   = (p - 1) / NT;
        end
        return e;
    endfunction

    function automatic bit hv(input int j);
        return (j >= 1 && j < hist.size()) ? hist[j] : 1'b0;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_col1"}, 32'(col1), HT - 1);
        chk({tag, "_row1"}, 32'(row1), VT - 1);
        chk({tag, "_col3"}, 32'(col3), HT - 1);
        chk({tag, "_row3"}, 32'(row3), VT - 1);
        chk({tag, "_outs1"}, 32'({v1, hs1, vs1, lt1, ft1, tp1, tf1}), 32'b0110000);
        chk({tag, "_outs3"}, 32'({v3, hs3, vs3, lt3, ft3, tp3, tf3}), 32'b0110000);
    endtask

    task automatic step();
        exp_t e1, e3;
        bit   pulse, tfe1, tfe3;
        @(posedge clk);
        k++;
        hist.push_back(trigger);
        pulse = hv(k - 2) & ~hv(k - 3);
        e1 = model(1, k);
        e3 = model(3, k);
        if (pulse) begin
            had1[e1.f] = 1'b1;
            had3[e3.f] = 1'b1;
        end
        tfe1 = (e1.f >= 0) && had1.exists(e1.f - 1);
        tfe3 = (e3.f >= 0) && had3.exists(e3.f - 1);
        @(negedge clk);
        chk("col1", 32'(col1), e1.col);
        chk("row1", 32'(row1), e1.row);
        chk("valid1", 32'(v1), 32'(e1.v));
        chk("hsync1", 32'(hs1), 32'(e1.hs));
        chk("vsync1", 32'(vs1), 32'(e1.vs));
        chk("line_tick1", 32'(lt1), 32'(e1.lt));
        chk("frame_tick1", 32'(ft1), 32'(e1.ft));
        chk("trig_pulse1", 32'(tp1), 32'(pulse));
        chk("trig_frame1", 32'(tf1), 32'(tfe1));
        chk("col3", 32'(col3), e3.col);
        chk("row3", 32'(row3), e3.row);
        chk("valid3", 32'(v3), 32'(e3.v));
        chk("hsync3", 32'(hs3), 32'(e3.hs));
        chk("vsync3", 32'(vs3), 32'(e3.vs));
        chk("line_tick3", 32'(lt3), 32'(e3.lt));
        chk("frame_tick3", 32'(ft3), 32'(e3.ft));
        chk("trig_pulse3", 32'(tp3), 32'(pulse));
        chk("trig_frame3", 32'(tf3), 32'(tfe3));
        if (ft1) begin
            if (last_ft1 >= 0) chk("frame_period1", k - last_ft1, NT);
            if (vframes > 0) chk("valid_per_frame1", vcount, HA * VA);
            vframes++;
            vcount   = 0;
            last_ft1 = k;
        end
        if (v1) vcount++;
        if (ft3) begin
            if (last_ft3 >= 0) chk("frame_period3", k - last_ft3, 3 * NT);
            last_ft3 = k;
        end
        if (lt1) begin
            if (last_lt1 >= 0) chk("line_period1", k - last_lt1, HT);
            last_lt1 = k;
        end
        if (lt3) begin
            if (last_lt3 >= 0) chk("line_period3", k - last_lt3, 3 * HT);
            last_lt3 = k;
        end
    endtask

    // Called with reset high; checks the held reset state and releases it.
    task automatic restart(input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset(tag);
        reset = 1'b0;
        k = 0;
        hist.delete();
        hist.push_back(1'b0);
        had1.delete();
        had3.delete();
        last_ft1 = -1; last_ft3 = -1; last_lt1 = -1; last_lt3 = -1;
        vcount = 0; vframes = 0;
    endtask

    task automatic wait_pos(input string tag, input int r, input int c);
        int n;
        n = 0;
        while (!(32'(row1) == r && 32'(col1) == c) && n < 3 * NT) begin
            step();
            n++;
        end
        chk(tag, 32'(row1) * HT + 32'(col1), r * HT + c);
    endtask

    task automatic run_random(input int cycles, input int thr);
        repeat (cycles) begin
            if ($urandom_range(thr) == 0) trigger = ~trigger;
            step();
        end
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        trigger = 1'b0;
        restart("rst0");

        // Long trigger at row 2: one pulse, latched at the next boundary only.
        wait_pos("reach_row2", 2, 0);
        trigger = 1'b1;
        repeat (20) step();
        trigger = 1'b0;
        repeat (2 * 3 * NT) step();

        // Pulse lands exactly on a PIX_DIV=1 frame_tick.
        n = 0;
        while (((k + 3 - 1) % NT) != 0 && n < 2 * NT) begin step(); n++; end
        chk("align_tick1", (k + 3 - 1) % NT, 0);
        trigger = 1'b1;
        repeat (4) step();
        trigger = 1'b0;
        repeat (3 * NT) step();

        // Pulse lands exactly on a PIX_DIV=3 frame_tick.
        n = 0;
        while (!(((k + 3) % 3 == 0) && ((((k + 3) / 3) - 1) % NT == 0)) && n < 6 * NT) begin
            step();
            n++;
        end
        chk("align_tick3", (((k + 3) / 3) - 1) % NT, 0);
        trigger = 1'b1;
        repeat (4) step();
        trigger = 1'b0;
        repeat (2 * 3 * NT) step();

        // Random trigger activity, alternating busy and quiet stretches.
        for (int seg = 0; seg < 6; seg++) begin
            run_random(300, (seg % 2 == 0) ? 6 : 400);
        end
        trigger = 1'b0;
        repeat (4) step();

        // Pending trigger in the current frame, then asynchronous reset at (3,5).
        wait_pos("reach_origin", 0, 0);
        trigger = 1'b1;
        repeat (5) step();
        trigger = 1'b0;
        wait_pos("reach_3_5", 3, 5);
        reset = 1'b1;
        #1;
        check_reset("async_rst");
        restart("rst1");
        repeat (2 * 3 * NT) step();
        run_random(600, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
